// File: rtl/ex_mem_latch_if.sv
// +----------------------------------------------------------------------------+
// | Module   : ex_mem_latch_if                                                 |
// | Purpose  : EX->MEM boundary bundle: execute-stage fields, pipeline         |
// |            controls, MEM-side registered fields and exception handshake.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface ex_mem_latch_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              ex_valid;
  logic [DATA_W-1:0] ex_result;
  logic              ex_overflow;
  logic              ex_set;
  logic              ex_is_set_op;
  logic              ex_ovf_trap_en;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic [DATA_W-1:0] ex_store_data;
  logic [DATA_W-1:0] ex_pc;
  logic              stall;
  logic              flush;
  logic              exc_ack;

  logic              mem_valid;
  logic [DATA_W-1:0] mem_result;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic              mem_mem_read;
  logic              mem_mem_write;
  logic [DATA_W-1:0] mem_store_data;
  logic              exc_valid;
  logic [DATA_W-1:0] exc_pc;
  logic              ex_stall_req;

  // Execute stage / hazard control side.
  modport master (
    output ex_valid, ex_result, ex_overflow, ex_set, ex_is_set_op,
           ex_ovf_trap_en, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_store_data, ex_pc, stall, flush, exc_ack,
    input  mem_valid, mem_result, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_store_data, exc_valid, exc_pc, ex_stall_req
  );

  // The pipeline register itself.
  modport slave (
    input  ex_valid, ex_result, ex_overflow, ex_set, ex_is_set_op,
           ex_ovf_trap_en, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_store_data, ex_pc, stall, flush, exc_ack,
    output mem_valid, mem_result, mem_rd, mem_reg_write, mem_mem_read,
           mem_mem_write, mem_store_data, exc_valid, exc_pc, ex_stall_req
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_latch.sv
// +----------------------------------------------------------------------------+
// | Module   : ex_mem_latch                                                    |
// | Purpose  : EX/MEM pipeline register with SLT substitution, precise signed  |
// |            overflow trap (held until acknowledged), stall and flush.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ex_mem_latch #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  wire logic     clk,
  input  wire logic     reset,
  ex_mem_latch_if.slave bus
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_pend = 1'b1;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;

  logic              w_exc_valid;
  logic              w_load;
  logic              w_bubble;
  logic              w_trap;
  logic [DATA_W-1:0] w_result;

  logic              r_valid;
  logic [DATA_W-1:0] r_result;
  logic [REG_AW-1:0] r_rd;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [DATA_W-1:0] r_store_data;
  logic [DATA_W-1:0] r_exc_pc;

  // State register: the pending-exception flag lives here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ack is honoured in PEND even on a flush edge; flush alone never clears it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_load && w_trap) w_state_nxt = c_st_pend;
      c_st_pend: if (bus.exc_ack)      w_state_nxt = c_st_idle;
      default:                         w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_exc_valid = (r_state == c_st_pend);
    w_bubble    = bus.flush | w_exc_valid;
    w_load      = ~bus.flush & ~w_exc_valid & ~bus.stall;
    w_trap      = bus.ex_valid & bus.ex_ovf_trap_en & bus.ex_overflow & ~w_exc_valid;
    w_result    = bus.ex_is_set_op ? {{(DATA_W-1){1'b0}}, bus.ex_set} : bus.ex_result;
  end

  // Bubbles clear valid and side effects only; data fields keep their value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_result     <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_store_data <= '0;
      r_exc_pc     <= '0;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else if (w_load) begin
      r_valid      <= bus.ex_valid;
      r_result     <= w_result;
      r_rd         <= bus.ex_rd;
      r_reg_write  <= bus.ex_valid & bus.ex_reg_write & ~w_trap;
      r_mem_read   <= bus.ex_valid & bus.ex_mem_read  & ~w_trap;
      r_mem_write  <= bus.ex_valid & bus.ex_mem_write & ~w_trap;
      r_store_data <= bus.ex_store_data;
      if (w_trap) begin
        r_exc_pc   <= bus.ex_pc;
      end
    end
  end

  assign bus.mem_valid      = r_valid;
  assign bus.mem_result     = r_result;
  assign bus.mem_rd         = r_rd;
  assign bus.mem_reg_write  = r_reg_write;
  assign bus.mem_mem_read   = r_mem_read;
  assign bus.mem_mem_write  = r_mem_write;
  assign bus.mem_store_data = r_store_data;
  assign bus.exc_valid      = w_exc_valid;
  assign bus.exc_pc         = r_exc_pc;
  assign bus.ex_stall_req   = w_exc_valid;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_latch.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_ex_mem_latch                                                 |
// | Purpose  : Directed vector table, corner sequences and random stimulus     |
// |            against a rule-level model of the EX/MEM register.             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ex_mem_latch;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  ex_mem_latch_if #(.DATA_W(32), .REG_AW(5)) bus ();

  ex_mem_latch #(.DATA_W(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [31:0] result;
    logic        ovf;
    logic        set;
    logic        is_set;
    logic        trap_en;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic        ack;
    logic        e_valid;
    logic [31:0] e_result;
    logic        e_rw;
    logic        e_exc;
    logic [31:0] e_pc;
  } vec_t;

  // Reference state: what the MEM side should show after each edge.
  logic        m_valid, m_rw, m_mr, m_mw, m_exc;
  logic [31:0] m_result, m_sd, m_exc_pc;
  logic [4:0]  m_rd;

  function automatic vec_t mk(logic v, logic [31:0] res, logic ovf, logic st_bit,
                              logic is_set, logic ten, logic [4:0] rd, logic rw,
                              logic [31:0] pc, logic stl, logic fl, logic ack,
                              logic ev, logic [31:0] er, logic erw, logic ee,
                              logic [31:0] epc);
    vec_t r;
    r.valid = v;   r.result = res; r.ovf = ovf;   r.set = st_bit;
    r.is_set = is_set; r.trap_en = ten; r.rd = rd; r.rw = rw; r.pc = pc;
    r.stall = stl; r.flush = fl;   r.ack = ack;
    r.e_valid = ev; r.e_result = er; r.e_rw = erw; r.e_exc = ee; r.e_pc = epc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_exc = 0;
    m_result = 0; m_sd = 0; m_exc_pc = 0; m_rd = 0;
  endtask

  // One edge worth of the pipeline-register rules, from the current inputs.
  task automatic model_step();
    logic trap;
    if (bus.flush || m_exc) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
      if (m_exc && bus.exc_ack) m_exc = 0;
    end else if (!bus.stall) begin
      trap     = bus.ex_valid && bus.ex_ovf_trap_en && bus.ex_overflow;
      m_valid  = bus.ex_valid;
      m_result = bus.ex_is_set_op ? 32'(bus.ex_set) : bus.ex_result;
      m_rd     = bus.ex_rd;
      m_sd     = bus.ex_store_data;
      m_rw     = bus.ex_valid && bus.ex_reg_write && !trap;
      m_mr     = bus.ex_valid && bus.ex_mem_read  && !trap;
      m_mw     = bus.ex_valid && bus.ex_mem_write && !trap;
      if (trap) begin
        m_exc    = 1;
        m_exc_pc = bus.ex_pc;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"}, 32'(bus.mem_valid),      32'(m_valid));
    chk({tag, ".result"}, bus.mem_result,         m_result);
    chk({tag, ".rd"},     32'(bus.mem_rd),        32'(m_rd));
    chk({tag, ".rw"},     32'(bus.mem_reg_write), 32'(m_rw));
    chk({tag, ".mr"},     32'(bus.mem_mem_read),  32'(m_mr));
    chk({tag, ".mw"},     32'(bus.mem_mem_write), 32'(m_mw));
    chk({tag, ".sd"},     bus.mem_store_data,     m_sd);
    chk({tag, ".exc"},    32'(bus.exc_valid),     32'(m_exc));
    chk({tag, ".excpc"},  bus.exc_pc,             m_exc_pc);
    chk({tag, ".sreq"},   32'(bus.ex_stall_req),  32'(m_exc));
  endtask

  task automatic apply(input vec_t v);
    bus.ex_valid       = v.valid;
    bus.ex_result      = v.result;
    bus.ex_overflow    = v.ovf;
    bus.ex_set         = v.set;
    bus.ex_is_set_op   = v.is_set;
    bus.ex_ovf_trap_en = v.trap_en;
    bus.ex_rd          = v.rd;
    bus.ex_reg_write   = v.rw;
    bus.ex_mem_read    = 1'b0;
    bus.ex_mem_write   = 1'b0;
    bus.ex_store_data  = 32'hA5A5_0000 ^ v.pc;
    bus.ex_pc          = v.pc;
    bus.stall          = v.stall;
    bus.flush          = v.flush;
    bus.exc_ack        = v.ack;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, ".valid"}, 32'(bus.mem_valid),      32'(v.e_valid));
    chk({tag, ".result"}, bus.mem_result,         v.e_result);
    chk({tag, ".rw"},     32'(bus.mem_reg_write), 32'(v.e_rw));
    chk({tag, ".exc"},    32'(bus.exc_valid),     32'(v.e_exc));
    chk({tag, ".excpc"},  bus.exc_pc,             v.e_pc);
    chk({tag, ".sreq"},   32'(bus.ex_stall_req),  32'(v.e_exc));
  endtask

  vec_t tbl[13];
  vec_t seq[4];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    reset = 1'b0;

    tbl[0]  = mk(1, 32'h7,         0, 0, 0, 0, 5,  1, 32'h10,  0, 0, 0, 1, 32'h7,         1, 0, 32'h0);
    tbl[1]  = mk(1, 32'hFFFF_FFFE, 0, 1, 1, 0, 6,  1, 32'h14,  0, 0, 0, 1, 32'h1,         1, 0, 32'h0);
    tbl[2]  = mk(1, 32'hFFFF_FFFE, 0, 0, 1, 0, 6,  1, 32'h18,  0, 0, 0, 1, 32'h0,         1, 0, 32'h0);
    tbl[3]  = mk(1, 32'h8000_0000, 1, 0, 0, 1, 7,  1, 32'h100, 0, 0, 0, 1, 32'h8000_0000, 0, 1, 32'h100);
    tbl[4]  = mk(1, 32'h55,        0, 0, 0, 0, 8,  1, 32'h104, 0, 0, 0, 0, 32'h8000_0000, 0, 1, 32'h100);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = mk(1, 32'h55,        0, 0, 0, 0, 8,  1, 32'h104, 0, 0, 1, 0, 32'h8000_0000, 0, 0, 32'h100);
    tbl[8]  = mk(1, 32'h55,        0, 0, 0, 0, 8,  1, 32'h104, 0, 0, 0, 1, 32'h55,        1, 0, 32'h100);
    tbl[9]  = mk(1, 32'h8000_0000, 1, 0, 0, 0, 9,  1, 32'h108, 0, 0, 0, 1, 32'h8000_0000, 1, 0, 32'h100);
    tbl[10] = mk(1, 32'h99,        0, 0, 0, 0, 10, 1, 32'h10C, 1, 0, 0, 1, 32'h8000_0000, 1, 0, 32'h100);
    tbl[11] = tbl[10];
    tbl[12] = mk(1, 32'h99,        0, 0, 0, 0, 10, 1, 32'h10C, 1, 1, 0, 0, 32'h8000_0000, 0, 0, 32'h100);

    for (int i = 0; i < 13; i++) begin
      apply(tbl[i]);
      cycle();
      check_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Trap on a stalled instruction is recorded only once it loads; flush keeps it pending.
    seq[0] = mk(1, 32'h8000_0001, 1, 0, 0, 1, 3, 1, 32'h200, 1, 0, 0, 0, 32'h8000_0000, 0, 0, 32'h100);
    seq[1] = seq[0];
    seq[2] = mk(1, 32'h8000_0001, 1, 0, 0, 1, 3, 1, 32'h200, 0, 0, 0, 1, 32'h8000_0001, 0, 1, 32'h200);
    seq[3] = mk(1, 32'h1234,      0, 0, 0, 0, 4, 1, 32'h204, 0, 1, 0, 0, 32'h8000_0001, 0, 1, 32'h200);
    for (int i = 0; i < 4; i++) begin
      apply(seq[i]);
      cycle();
      check_vec($sformatf("seq%0d", i), seq[i]);
    end

    // Asynchronous reset between edges while the exception is pending.
    apply(mk(1, 32'hFFFF_FFFF, 1, 1, 1, 1, 31, 1, 32'hFFFF_FFFC, 1, 1, 1, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("async_reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 400; i++) begin
      bus.ex_valid       = ($urandom_range(0, 9) < 8);
      bus.ex_result      = $urandom;
      bus.ex_overflow    = ($urandom_range(0, 9) < 3);
      bus.ex_set         = 1'($urandom);
      bus.ex_is_set_op   = ($urandom_range(0, 9) < 2);
      bus.ex_ovf_trap_en = 1'($urandom);
      bus.ex_rd          = 5'($urandom);
      bus.ex_reg_write   = 1'($urandom);
      bus.ex_mem_read    = 1'($urandom);
      bus.ex_mem_write   = 1'($urandom);
      bus.ex_store_data  = $urandom;
      bus.ex_pc          = $urandom & 32'hFFFF_FFFC;
      bus.stall          = ($urandom_range(0, 9) < 2);
      bus.flush          = ($urandom_range(0, 9) < 1);
      bus.exc_ack        = ($urandom_range(0, 9) < 3);
      cycle();
      check_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
